frame_config_ctrl: RTL and testbench

FRAME_CONFIG_CTRL -- requirements
Module: frame_config_ctrl

---
 rtl/frame_config_ctrl.sv | 168 ++++++++++++++++
 tb/tb_frame_config_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_config_ctrl.sv
`timescale 1ns/1ps
// frame_config_ctrl
//   Streams bitstream words into a per-column frame buffer one row at a time.
//   Once all rows of a frame are loaded, it pulses the one-hot strobe for that
//   frame. After the last frame it pulses done and returns to idle.
//
//   Optional feature (macro CFG_CHECKSUM_EN): the block keeps a running XOR of
//   every accepted frame word. After the last frame it accepts one extra
//   checksum word, and err latches (word != XOR).
//
// Ports
//   UserCLK      in   1              only clock, rising edge
//   Reset        in   1              synchronous, active-high
//   start        in   1              begin a column pass (sampled in IDLE only)
//   s_data       in   32             bitstream word
//   s_valid      in   1              s_data valid
//   s_ready      out  1              word accepted when s_valid & s_ready
//   FrameData    out  NUM_ROWS*32    assembled frame, row r at [32r+31:32r]
//   FrameStrobe  out  NUM_FRAMES     one-hot frame write strobe
//   busy         out  1              high outside IDLE
//   done         out  1              one-cycle completion pulse
//   err          out  1              checksum mismatch (0 without the macro)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting row words of the current frame
// STROBE | frame complete, pulse FrameStrobe[frame_cnt]
// CHECK  | accepting the checksum word (CFG_CHECKSUM_EN only)
// DONE   | one-cycle done pulse, then back to IDLE
module frame_config_ctrl #(
  parameter int NUM_ROWS   = 16,
  parameter int NUM_FRAMES = 20
) (
  input  logic                     UserCLK,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [31:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NUM_ROWS*32-1:0]   FrameData,
  output logic [NUM_FRAMES-1:0]    FrameStrobe,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STROBE = 3'd2,
`ifdef CFG_CHECKSUM_EN
    CHECK  = 3'd3,
`endif
    DONE   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [ROW_W-1:0]           row_cnt_q, row_cnt_d;
  logic [FRM_W-1:0]           frame_cnt_q, frame_cnt_d;
  logic [NUM_ROWS-1:0][31:0]  frame_q, frame_d;
  logic                       xfer;

`ifdef CFG_CHECKSUM_EN
  logic        err_q, err_d;
  logic [31:0] xor_q, xor_d;

  assign s_ready = (state_q == LOAD) || (state_q == CHECK);
  assign err     = err_q;
`else
  assign s_ready = (state_q == LOAD);
  assign err     = 1'b0;
`endif

  assign xfer      = s_valid & s_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign FrameData = frame_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_d     = frame_q;
    FrameStrobe = '0;
`ifdef CFG_CHECKSUM_EN
    err_d       = err_q;
    xor_d       = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          row_cnt_d   = '0;
          frame_cnt_d = '0;
`ifdef CFG_CHECKSUM_EN
          err_d       = 1'b0;
          xor_d       = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
          frame_d[row_cnt_q] = s_data;
`ifdef CFG_CHECKSUM_EN
          xor_d = xor_q ^ s_data;
`endif
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            state_d   = STROBE;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end
      STROBE: begin
        FrameStrobe[frame_cnt_q] = 1'b1;
        if (frame_cnt_q != FRM_LAST) begin
          frame_cnt_d = frame_cnt_q + FRM_W'(1);
          state_d     = LOAD;
        end else begin
`ifdef CFG_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          err_d   = (s_data != xor_q);
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      frame_cnt_q <= '0;
      frame_q     <= '0;
`ifdef CFG_CHECKSUM_EN
      err_q       <= 1'b0;
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
`ifdef CFG_CHECKSUM_EN
      err_q       <= err_d;
      xor_q       <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_config_ctrl.sv
`timescale 1ns/1ps
module tb_frame_config_ctrl;

  localparam int NR = 2;
  localparam int NF = 3;
`ifdef CFG_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic             UserCLK = 1'b0;
  logic             Reset   = 1'b1;
  logic             start   = 1'b0;
  logic [31:0]      s_data  = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [NR*32-1:0] FrameData;
  logic [NF-1:0]    FrameStrobe;
  logic             busy, done, err;

  frame_config_ctrl #(.NUM_ROWS(NR), .NUM_FRAMES(NF)) dut (
    .UserCLK(UserCLK), .Reset(Reset), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .FrameData(FrameData),
    .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .err(err)
  );

  always #5 UserCLK = ~UserCLK;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [NF-1:0]    stb_q[$];
  logic [NR*32-1:0] dat_q[$];
  int               scyc_q[$];
  int               done_q[$];

  logic [31:0] W [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};

  always @(posedge UserCLK) cyc <= cyc + 1;

  // Events are stamped with the index of the edge that samples them.
  always @(negedge UserCLK) begin
    if (FrameStrobe != '0) begin
      stb_q.push_back(FrameStrobe);
      dat_q.push_back(FrameData);
      scyc_q.push_back(cyc + 1);
    end
    if (done) done_q.push_back(cyc + 1);
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic clear_logs();
    stb_q.delete(); dat_q.delete(); scyc_q.delete(); done_q.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    bit sent = 0;
    s_valid = 1'b1;
    s_data  = w;
    for (int t = 0; t < 50 && !sent; t++) begin
      if (s_ready) sent = 1;
      tick();
    end
    if (!sent) check_vec("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 100 && done_q.size() == 0; t++) tick();
    if (done_q.size() == 0) check_vec("done_timeout", 64'd0, 64'd1);
    tick(); tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_vec({tag, "_data"},   64'(FrameData),   64'd0);
    check_vec({tag, "_strobe"}, 64'(FrameStrobe), 64'd0);
    check_vec({tag, "_ready"},  64'(s_ready),     64'd0);
    check_vec({tag, "_busy"},   64'(busy),        64'd0);
    check_vec({tag, "_done"},   64'(done),        64'd0);
    check_vec({tag, "_err"},    64'(err),         64'd0);
  endtask

  task automatic run_pass(input string tag, input int stall, input bit poke_start,
                          input logic [31:0] csum);
    int c0;
    clear_logs();
    start = 1'b1;
    tick();
    c0 = cyc;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (poke_start && i == 1) start = 1'b1;
      if (poke_start && i == 4) start = 1'b0;
      send_word(W[i]);
      if (i == 0 && stall > 0) begin
        s_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          check_vec({tag, "_stall_ready"}, 64'(s_ready), 64'd1);
        end
        check_vec({tag, "_stall_nostrobe"}, 64'(stb_q.size()), 64'd0);
      end
    end
`ifdef CFG_CHECKSUM_EN
    send_word(csum);
`endif
    s_valid = 1'b0;
    s_data  = '0;
    wait_done();
    check_vec({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0)
      check_vec({tag, "_latency"}, 64'(done_q[0] - c0), 64'(10 + stall + EXTRA));
    check_vec({tag, "_strobe_count"}, 64'(stb_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < stb_q.size(); k++) begin
      check_vec({tag, "_strobe_val"}, 64'(stb_q[k]), 64'(3'b001 << k));
      check_vec({tag, "_strobe_data"}, 64'(dat_q[k]), {W[2*k+1], W[2*k]});
      check_vec({tag, "_strobe_cyc"}, 64'(scyc_q[k] - c0), 64'(3*k + 3 + stall));
    end
    check_vec({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    check_outputs_zero("reset");
    Reset = 1'b0;
    tick();

    // back-to-back pass
    run_pass("basic", 0, 1'b0, 32'h77);
    check_vec("basic_hold_data", 64'(FrameData), {32'h66, 32'h55});

    // idle with s_valid high accepts nothing
    clear_logs();
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      check_vec("idle_ready", 64'(s_ready), 64'd0);
      tick();
    end
    check_vec("idle_busy", 64'(busy), 64'd0);
    check_vec("idle_nostrobe", 64'(stb_q.size()), 64'd0);
    check_vec("idle_hold_data", 64'(FrameData), {32'h66, 32'h55});
    s_valid = 1'b0;

    // stall of 5 cycles after the first word
    run_pass("stall", 5, 1'b0, 32'h77);

    // start pulsed during LOAD is ignored
    run_pass("poke", 0, 1'b1, 32'h77);

    // reset mid-frame after the 3rd word
    clear_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(W[0]); send_word(W[1]); send_word(W[2]);
    check_vec("midrst_busy_before", 64'(busy), 64'd1);
    Reset   = 1'b1;
    s_valid = 1'b0;
    tick();
    check_outputs_zero("midrst");
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_vec("midrst_strobes", 64'(stb_q.size()), 64'd1);
    check_vec("midrst_idle_busy", 64'(busy), 64'd0);
    run_pass("restart", 0, 1'b0, 32'h77);

`ifdef CFG_CHECKSUM_EN
    check_vec("csum_good_err", 64'(err), 64'd0);
    run_pass("csum_bad", 0, 1'b0, 32'h00);
    check_vec("csum_bad_err", 64'(err), 64'd1);
    tick(); tick(); tick();
    check_vec("csum_bad_err_hold", 64'(err), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_vec("csum_start_clears_err", 64'(err), 64'd0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
`else
    check_vec("err_const", 64'(err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
